// File: rtl/axi_ad7124_pkg.sv
// Shared types and constants for the AD7124 up-bus arbiter.
// The optional WAIT timeout is enabled by the AD7124_UP_ARB_TIMEOUT_EN macro.
package axi_ad7124_pkg;

  localparam int UP_ADDR_W = 14;
  localparam int UP_DATA_W = 32;

  // Read data returned to the owner when a transaction is force-completed.
  localparam logic [UP_DATA_W-1:0] UP_TIMEOUT_RDATA = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_HOST = 1'b0,
    PORT_SCAN = 1'b1
  } port_e;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

  // The port that did not win last time gets priority on a tie.
  function automatic port_e other_port(input port_e p);
    return (p == PORT_HOST) ? PORT_SCAN : PORT_HOST;
  endfunction

endpackage

// File: rtl/axi_ad7124_up_slot.sv
// Per-port request capture: one write slot and one read slot, each holding
// its address (and write data) until the arbiter returns the matching ack.
module axi_ad7124_up_slot
  import axi_ad7124_pkg::*;
(
  input  logic                 up_clk,
  input  logic                 up_rstn,
  input  logic                 wreq,
  input  logic                 rreq,
  input  logic [UP_ADDR_W-1:0] waddr,
  input  logic [UP_ADDR_W-1:0] raddr,
  input  logic [UP_DATA_W-1:0] wdata,
  input  logic                 wclr,
  input  logic                 rclr,
  output logic                 wpend,
  output logic                 rpend,
  output logic [UP_ADDR_W-1:0] waddr_q,
  output logic [UP_ADDR_W-1:0] raddr_q,
  output logic [UP_DATA_W-1:0] wdata_q
);

  // Write slot: clear first, then accept a new request into a free slot;
  // a request into an occupied slot is dropped.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (!up_rstn) begin
      wpend   <= 1'b0;
      // NOTE: address/data holding registers are reset too; they are few and
      // this keeps every downstream-visible value defined out of reset.
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (wclr) begin
        wpend <= 1'b0;
      end
      if (wreq && (!wpend || wclr)) begin
        wpend   <= 1'b1;
        waddr_q <= waddr;
        wdata_q <= wdata;
      end
    end
  end

  // Read slot: same clear-then-set behaviour as the write slot.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      rpend   <= 1'b0;
      raddr_q <= '0;
    end else begin
      if (rclr) begin
        rpend <= 1'b0;
      end
      if (rreq && (!rpend || rclr)) begin
        rpend   <= 1'b1;
        raddr_q <= raddr;
      end
    end
  end

endmodule

// File: rtl/axi_ad7124_up_arb.sv
// Two-port arbiter (host / scan sequencer) sharing the AD7124 up register bus.
// Serialises one transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature: define AD7124_UP_ARB_TIMEOUT_EN to force-complete a WAIT
// after TIMEOUT_CYCLES cycles and count such events in timeout_cnt.
module axi_ad7124_up_arb
  import axi_ad7124_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 up_clk,
  input  logic                 up_rstn,
  // host port
  input  logic                 h_up_wreq,
  input  logic                 h_up_rreq,
  input  logic [UP_ADDR_W-1:0] h_up_waddr,
  input  logic [UP_ADDR_W-1:0] h_up_raddr,
  input  logic [UP_DATA_W-1:0] h_up_wdata,
  output logic                 h_up_wack,
  output logic                 h_up_rack,
  output logic [UP_DATA_W-1:0] h_up_rdata,
  // scan-sequencer port
  input  logic                 s_up_wreq,
  input  logic                 s_up_rreq,
  input  logic [UP_ADDR_W-1:0] s_up_waddr,
  input  logic [UP_ADDR_W-1:0] s_up_raddr,
  input  logic [UP_DATA_W-1:0] s_up_wdata,
  output logic                 s_up_wack,
  output logic                 s_up_rack,
  output logic [UP_DATA_W-1:0] s_up_rdata,
  // downstream up bus
  output logic                 up_wreq,
  output logic                 up_rreq,
  output logic [UP_ADDR_W-1:0] up_waddr,
  output logic [UP_ADDR_W-1:0] up_raddr,
  output logic [UP_DATA_W-1:0] up_wdata,
  input  logic                 up_wack,
  input  logic                 up_rack,
  input  logic [UP_DATA_W-1:0] up_rdata,
  output logic [15:0]          timeout_cnt
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("axi_ad7124_up_arb: TIMEOUT_CYCLES must be in 1..65535");
  end

  arb_state_e state, state_next;
  port_e      gnt_port, last_served, sel_port;
  dir_e       gnt_dir, sel_dir;

  logic                 h_wpend, h_rpend, s_wpend, s_rpend;
  logic [UP_ADDR_W-1:0] h_waddr_q, h_raddr_q, s_waddr_q, s_raddr_q;
  logic [UP_DATA_W-1:0] h_wdata_q, s_wdata_q;
  logic                 h_wclr, h_rclr, s_wclr, s_rclr;

  logic [UP_ADDR_W-1:0] sel_waddr, sel_raddr;
  logic [UP_DATA_W-1:0] sel_wdata, resp_rdata;
  logic                 h_any, s_any, any_pend;
  logic                 match_ack, timeout_hit, grant_fire, done_fire;

  axi_ad7124_up_slot u_host_slot (
    .up_clk  (up_clk),
    .up_rstn (up_rstn),
    .wreq    (h_up_wreq),
    .rreq    (h_up_rreq),
    .waddr   (h_up_waddr),
    .raddr   (h_up_raddr),
    .wdata   (h_up_wdata),
    .wclr    (h_wclr),
    .rclr    (h_rclr),
    .wpend   (h_wpend),
    .rpend   (h_rpend),
    .waddr_q (h_waddr_q),
    .raddr_q (h_raddr_q),
    .wdata_q (h_wdata_q)
  );

  axi_ad7124_up_slot u_scan_slot (
    .up_clk  (up_clk),
    .up_rstn (up_rstn),
    .wreq    (s_up_wreq),
    .rreq    (s_up_rreq),
    .waddr   (s_up_waddr),
    .raddr   (s_up_raddr),
    .wdata   (s_up_wdata),
    .wclr    (s_wclr),
    .rclr    (s_rclr),
    .wpend   (s_wpend),
    .rpend   (s_rpend),
    .waddr_q (s_waddr_q),
    .raddr_q (s_raddr_q),
    .wdata_q (s_wdata_q)
  );

  assign h_any    = h_wpend | h_rpend;
  assign s_any    = s_wpend | s_rpend;
  assign any_pend = h_any | s_any;

  // Only the ack matching the granted direction ends a WAIT.
  assign match_ack  = (gnt_dir == DIR_WR) ? up_wack : up_rack;
  assign grant_fire = (state == ST_IDLE) && any_pend;
  assign done_fire  = (state == ST_WAIT) && (match_ack || timeout_hit);
  assign resp_rdata = match_ack ? up_rdata : UP_TIMEOUT_RDATA;

  // The owner's slot is released during the RESP cycle.
  assign h_wclr = (state == ST_RESP) && (gnt_port == PORT_HOST) && (gnt_dir == DIR_WR);
  assign h_rclr = (state == ST_RESP) && (gnt_port == PORT_HOST) && (gnt_dir == DIR_RD);
  assign s_wclr = (state == ST_RESP) && (gnt_port == PORT_SCAN) && (gnt_dir == DIR_WR);
  assign s_rclr = (state == ST_RESP) && (gnt_port == PORT_SCAN) && (gnt_dir == DIR_RD);

  // Grant choice: round-robin between ports, write before read within a port.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a value unassigned (no latch inference).
    sel_port  = PORT_HOST;
    sel_dir   = DIR_WR;
    sel_waddr = '0;
    sel_raddr = '0;
    sel_wdata = '0;
    if (h_any && s_any) begin
      sel_port = other_port(last_served);
    end else if (s_any) begin
      sel_port = PORT_SCAN;
    end
    if (sel_port == PORT_HOST) begin
      sel_dir   = h_wpend ? DIR_WR : DIR_RD;
      sel_waddr = h_waddr_q;
      sel_raddr = h_raddr_q;
      sel_wdata = h_wdata_q;
    end else begin
      sel_dir   = s_wpend ? DIR_WR : DIR_RD;
      sel_waddr = s_waddr_q;
      sel_raddr = s_raddr_q;
      sel_wdata = s_wdata_q;
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (any_pend) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (match_ack || timeout_hit) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remember the owner of the transaction in flight and the round-robin pointer.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      gnt_port    <= PORT_HOST;
      gnt_dir     <= DIR_WR;
      last_served <= PORT_SCAN;
    end else if (grant_fire) begin
      gnt_port    <= sel_port;
      gnt_dir     <= sel_dir;
      last_served <= sel_port;
    end
  end

  // Registered outputs: downstream request on entry to ISSUE, owner ack on
  // entry to RESP. Addresses and read data hold until their next update.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      up_wreq    <= 1'b0;
      up_rreq    <= 1'b0;
      up_waddr   <= '0;
      up_raddr   <= '0;
      up_wdata   <= '0;
      h_up_wack  <= 1'b0;
      h_up_rack  <= 1'b0;
      h_up_rdata <= '0;
      s_up_wack  <= 1'b0;
      s_up_rack  <= 1'b0;
      s_up_rdata <= '0;
    end else begin
      up_wreq <= grant_fire && (sel_dir == DIR_WR);
      up_rreq <= grant_fire && (sel_dir == DIR_RD);
      if (grant_fire && (sel_dir == DIR_WR)) begin
        up_waddr <= sel_waddr;
        up_wdata <= sel_wdata;
      end
      if (grant_fire && (sel_dir == DIR_RD)) begin
        up_raddr <= sel_raddr;
      end
      h_up_wack <= done_fire && (gnt_port == PORT_HOST) && (gnt_dir == DIR_WR);
      h_up_rack <= done_fire && (gnt_port == PORT_HOST) && (gnt_dir == DIR_RD);
      s_up_wack <= done_fire && (gnt_port == PORT_SCAN) && (gnt_dir == DIR_WR);
      s_up_rack <= done_fire && (gnt_port == PORT_SCAN) && (gnt_dir == DIR_RD);
      if (done_fire && (gnt_port == PORT_HOST) && (gnt_dir == DIR_RD)) begin
        h_up_rdata <= resp_rdata;
      end
      if (done_fire && (gnt_port == PORT_SCAN) && (gnt_dir == DIR_RD)) begin
        s_up_rdata <= resp_rdata;
      end
    end
  end

`ifdef AD7124_UP_ARB_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic [15:0] timeout_cnt_q;

  // WAIT-cycle counter, restarted during ISSUE.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state == ST_WAIT) && !match_ack && (wait_cnt == WAIT_LAST);

  // Saturating count of forced completions.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      timeout_cnt_q <= '0;
    end else if (timeout_hit && (timeout_cnt_q != 16'hFFFF)) begin
      timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign timeout_cnt = timeout_cnt_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_cnt = '0;
`endif

endmodule
